multicycle_controller: RTL and testbench

Main control unit of the multicycle RISC-V core. It sits directly upstream of the datapath's 4-to-1 select muxes (result, ALU source A, ALU source B) and drives their 2-bit select lines together with every datapath write enable. It sequences each instruction through fetch, decode, execute, memory and writeback states, one state per clock.

---
 rtl/multicycle_pkg.sv | 81 ++++++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 147 ++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Package  : multicycle_pkg
// Purpose  : Shared state, opcode and mux-select encodings of the multicycle core.
// Revision : 1.0
// ============================================================================
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI_WB   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] c_op_r_type = 7'b0110011;
    localparam logic [6:0] c_op_i_alu  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;
    localparam logic [1:0] c_res_imm       = 2'b11;

    localparam logic [1:0] c_src_a_pc    = 2'b00;
    localparam logic [1:0] c_src_a_oldpc = 2'b01;
    localparam logic [1:0] c_src_a_rd1   = 2'b10;

    localparam logic [1:0] c_src_b_rd2  = 2'b00;
    localparam logic [1:0] c_src_b_imm  = 2'b01;
    localparam logic [1:0] c_src_b_four = 2'b10;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;
    localparam logic [2:0] c_f3_blt = 3'b100;
    localparam logic [2:0] c_f3_bge = 3'b101;

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            c_op_store:  return c_imm_s;
            c_op_branch: return c_imm_b;
            c_op_jal:    return c_imm_j;
            c_op_lui:    return c_imm_u;
            default:     return c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : multicycle_controller_if
// Purpose   : Instruction fields, ALU flags and datapath controls.
// Revision  : 1.0
// ============================================================================
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       lt;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;

    modport master (
        input  op, funct3, funct7_5, zero, lt,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );

    modport slave (
        output op, funct3, funct7_5, zero, lt,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps alu_op and instruction function fields to alu_control.
// Revision : 1.0
// ============================================================================
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = c_alu_add;
        case (alu_op)
            ALU_OP_ADD: alu_control = c_alu_add;
            ALU_OP_SUB: alu_control = c_alu_sub;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7_5 in an I-type is immediate bits, so only R-type can subtract
                    3'b000:  alu_control = (op_5 & funct7_5) ? c_alu_sub : c_alu_add;
                    3'b010:  alu_control = c_alu_slt;
                    3'b110:  alu_control = c_alu_or;
                    3'b111:  alu_control = c_alu_and;
                    default: alu_control = c_alu_add;
                endcase
            end
            default: alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Per-instruction state sequencer driving datapath selects/enables.
// Revision : 1.0
// ============================================================================
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_controller_if.master        bus
);

    state_t     r_state;
    state_t     w_state_next;
    alu_op_t    w_alu_op;
    logic [2:0] w_alu_control;
    logic       w_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_state_next;
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .op_5        (bus.op[5]),
        .alu_control (w_alu_control)
    );

    always_comb begin
        case (bus.funct3)
            c_f3_beq: w_branch_taken = bus.zero;
            c_f3_bne: w_branch_taken = ~bus.zero;
            c_f3_blt: w_branch_taken = bus.lt;
            c_f3_bge: w_branch_taken = ~bus.lt;
            default:  w_branch_taken = 1'b0;
        endcase
    end

    // Reset masks everything so a half-finished store cannot write.
    assign bus.alu_control = rst_n ? w_alu_control : c_alu_add;

    always_comb begin
        w_state_next   = S_FETCH;
        w_alu_op       = ALU_OP_ADD;
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = c_res_aluout;
        bus.alu_src_a  = c_src_a_pc;
        bus.alu_src_b  = c_src_b_rd2;
        bus.imm_src    = c_imm_i;
        case (r_state)
            S_FETCH: begin
                bus.ir_write   = 1'b1;
                bus.pc_write   = 1'b1;
                bus.alu_src_b  = c_src_b_four;
                bus.result_src = c_res_aluresult;
                w_state_next   = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = c_src_a_oldpc;
                bus.alu_src_b = c_src_b_imm;
                bus.imm_src   = imm_src_for(bus.op);
                case (bus.op)
                    c_op_load, c_op_store: w_state_next = S_MEMADR;
                    c_op_r_type:           w_state_next = S_EXEC_R;
                    c_op_i_alu, c_op_jalr: w_state_next = S_EXEC_I;
                    c_op_branch:           w_state_next = S_BRANCH;
                    c_op_jal:              w_state_next = S_JAL;
                    c_op_lui:              w_state_next = S_LUI_WB;
                    default:               w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = c_src_a_rd1;
                bus.alu_src_b = c_src_b_imm;
                bus.imm_src   = imm_src_for(bus.op);
                w_state_next  = (bus.op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adr_src  = 1'b1;
                w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = c_res_data;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = c_src_a_rd1;
                w_alu_op      = ALU_OP_FUNCT;
                w_state_next  = S_ALUWB;
            end
            S_EXEC_I: begin
                bus.alu_src_a = c_src_a_rd1;
                bus.alu_src_b = c_src_b_imm;
                if (bus.op == c_op_jalr) begin
                    w_state_next = S_JALR;
                end else begin
                    w_alu_op     = ALU_OP_FUNCT;
                    w_state_next = S_ALUWB;
                end
            end
            S_ALUWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = c_src_a_rd1;
                w_alu_op      = ALU_OP_SUB;
                bus.pc_write  = w_branch_taken;
            end
            S_JAL, S_JALR: begin
                bus.pc_write  = 1'b1;
                bus.alu_src_a = c_src_a_oldpc;
                bus.alu_src_b = c_src_b_four;
                w_state_next  = S_ALUWB;
            end
            S_LUI_WB: begin
                bus.result_src = c_res_imm;
                bus.imm_src    = c_imm_u;
                bus.reg_write  = 1'b1;
            end
            default: w_state_next = S_FETCH;
        endcase
        if (!rst_n) begin
            bus.pc_write   = 1'b0;
            bus.adr_src    = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.result_src = c_res_aluout;
            bus.alu_src_a  = c_src_a_pc;
            bus.alu_src_b  = c_src_b_rd2;
            bus.imm_src    = c_imm_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed instruction traces checked per cycle through a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;
    event   chk_ev;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, A, B, imm_src, alu_control}
    function automatic logic [16:0] vec(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] imm, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
    endfunction

    function automatic logic [16:0] v_zero();     return vec(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_fetch();    return vec(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_decode(input logic [2:0] imm);
        return vec(0,0,0,0,0,2'b00,2'b01,2'b01,imm,3'b000);
    endfunction
    function automatic logic [16:0] v_memadr(input logic [2:0] imm);
        return vec(0,0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000);
    endfunction
    function automatic logic [16:0] v_memread();  return vec(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_memwb();    return vec(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_memwrite(); return vec(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_exec_r(input logic [2:0] alu);
        return vec(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,alu);
    endfunction
    function automatic logic [16:0] v_exec_i(input logic [2:0] alu);
        return vec(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,alu);
    endfunction
    function automatic logic [16:0] v_aluwb();    return vec(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_branch(input logic pcw);
        return vec(pcw,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b001);
    endfunction
    function automatic logic [16:0] v_jump();     return vec(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000); endfunction
    function automatic logic [16:0] v_lui();      return vec(0,0,0,0,1,2'b11,2'b00,2'b00,3'b100,3'b000); endfunction

    function automatic logic [16:0] actual();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control};
    endfunction

    task automatic push(input logic [16:0] v, input string name);
        exp_t e;
        e.v = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input logic [16:0] v, input string name);
        push(v, name);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                          input logic z, input logic l);
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7_5 = f75;
        bus.zero = z;
        bus.lt = l;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [16:0] a;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = actual();
                checks++;
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s got=%05h exp=%05h", e.name, a, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        set_in(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(v_zero(), "reset_hold");

        // lw
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(v_fetch(), "lw_fetch");
        step(v_decode(3'b000), "lw_decode");
        step(v_memadr(3'b000), "lw_memadr");
        step(v_memread(), "lw_memread");
        step(v_memwb(), "lw_memwb");

        // bne not taken, then taken
        set_in(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
        step(v_fetch(), "bne_fetch");
        step(v_decode(3'b010), "bne_decode");
        step(v_branch(1'b0), "bne_z1_branch");
        set_in(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "bne2_fetch");
        step(v_decode(3'b010), "bne2_decode");
        step(v_branch(1'b1), "bne_z0_branch");

        // beq taken, blt taken, bge not taken
        set_in(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
        step(v_fetch(), "beq_fetch");
        step(v_decode(3'b010), "beq_decode");
        step(v_branch(1'b1), "beq_branch");
        set_in(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
        step(v_fetch(), "blt_fetch");
        step(v_decode(3'b010), "blt_decode");
        step(v_branch(1'b1), "blt_branch");
        set_in(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
        step(v_fetch(), "bge_fetch");
        step(v_decode(3'b010), "bge_decode");
        step(v_branch(1'b0), "bge_branch");

        // R-type sub, or, slt, and
        set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
        step(v_fetch(), "sub_fetch");
        step(v_decode(3'b000), "sub_decode");
        step(v_exec_r(3'b001), "sub_exec_r");
        step(v_aluwb(), "sub_aluwb");
        set_in(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "or_fetch");
        step(v_decode(3'b000), "or_decode");
        step(v_exec_r(3'b011), "or_exec_r");
        step(v_aluwb(), "or_aluwb");
        set_in(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "slt_fetch");
        step(v_decode(3'b000), "slt_decode");
        step(v_exec_r(3'b101), "slt_exec_r");
        step(v_aluwb(), "slt_aluwb");
        set_in(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "and_fetch");
        step(v_decode(3'b000), "and_decode");
        step(v_exec_r(3'b010), "and_exec_r");
        step(v_aluwb(), "and_aluwb");

        // addi with funct7_5 set must still add
        set_in(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
        step(v_fetch(), "addi_fetch");
        step(v_decode(3'b000), "addi_decode");
        step(v_exec_i(3'b000), "addi_exec_i");
        step(v_aluwb(), "addi_aluwb");

        // jalr
        set_in(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "jalr_fetch");
        step(v_decode(3'b000), "jalr_decode");
        step(v_exec_i(3'b000), "jalr_exec_i");
        step(v_jump(), "jalr_jalr");
        step(v_aluwb(), "jalr_aluwb");

        // jal
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "jal_fetch");
        step(v_decode(3'b011), "jal_decode");
        step(v_jump(), "jal_jal");
        step(v_aluwb(), "jal_aluwb");

        // lui
        set_in(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "lui_fetch");
        step(v_decode(3'b100), "lui_decode");
        step(v_lui(), "lui_wb");

        // illegal opcode returns straight to FETCH
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "ill_fetch");
        step(v_decode(3'b000), "ill_decode");

        // sw, interrupted by a reset pulse during MEMWRITE
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        step(v_fetch(), "sw_fetch");
        step(v_decode(3'b001), "sw_decode");
        step(v_memadr(3'b001), "sw_memadr");
        push(v_memwrite(), "sw_memwrite");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(v_zero(), "sw_reset_drop");
        ->chk_ev;
        #1;
        rst_n = 1'b1;
        #1;
        push(v_fetch(), "sw_after_reset_fetch");
        ->chk_ev;
        @(posedge clk);
        #1;
        step(v_decode(3'b001), "sw_after_reset_decode");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
